conv_result_reader: RTL
=======================

CONV_RESULT_READER -- requirements
Module: conv_result_reader

Interface
REQ-001 Parameter DATA_W, default 8: width of one result word.
REQ-002 Parameter ADDR_W, default 3: memZ address width.
REQ-003 Parameter DEPTH, default 8: number of memZ words, at most 2**ADDR_W.
REQ-004 Port clk, input, 1: single clock, rising edge; all logic in this one domain.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port conv_done, input, 1: convolution core finished; level or pulse, sampled high in IDLE.
REQ-007 Port result_len, input, ADDR_W+1: number of words to read, latched on start.
REQ-008 Port memz_rd_en, output, 1: memZ read strobe.
REQ-009 Port memz_addr, output, ADDR_W: memZ read address.
REQ-010 Port memz_rdata, input, DATA_W: memZ read data, valid exactly 1 cycle after memz_rd_en.
REQ-011 Port out_data, output, DATA_W: streamed result word.
REQ-012 Port out_valid, output, 1: out_data valid.
REQ-013 Port out_ready, input, 1: sink accepts the word.
REQ-014 Port out_last, output, 1: current word is the final word of the frame.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port rd_done, output, 1: one-cycle pulse after the last word is accepted.

Function
REQ-017 FSM states: IDLE, READ, DRAIN, FINISH.
REQ-018 IDLE→READ when conv_done=1; latch len=min(result_len,DEPTH); clear rd_ptr and beat counter.
REQ-019 IDLE→FINISH directly when conv_done=1 and latched len=0; no memZ read and no beat issued.
REQ-020 READ: assert memz_rd_en with memz_addr=rd_ptr when (buffered words + reads in flight) < 2; rd_ptr increments per issued read.
REQ-021 READ→DRAIN in the cycle after the read at address len-1 is issued.
REQ-022 Data returned 1 cycle after a read is pushed into a 2-entry FIFO; FIFO head drives out_data.
REQ-023 out_valid = FIFO not empty; beat transfers when out_valid&out_ready; out_data stays stable while out_valid&!out_ready.
REQ-024 out_last=1 exactly on the beat with beat counter = len-1.
REQ-025 DRAIN→FINISH on the last-beat transfer; FINISH drives rd_done=1 for one cycle, then →IDLE.
REQ-026 With out_ready held at 1, sustained throughput SHALL be one beat per cycle; first out_valid 2 cycles after conv_done is sampled.
REQ-027 conv_done while busy=1 SHALL be ignored; no queuing of requests.
REQ-028 Simultaneous FIFO push and pop SHALL keep the occupancy count unchanged with no data loss.
REQ-029 Address and counter arithmetic is unsigned; rd_ptr never exceeds len-1, so no memZ address wraps.

Reset
REQ-030 While reset=0, state=IDLE and the FIFO is empty; memz_rd_en, out_valid, out_last, busy and rd_done are 0; memz_addr and out_data are 0.
REQ-031 Reset mid-frame aborts immediately; a data return still in flight after reset release is discarded.

Configuration
REQ-032 Macro CONV_READER_PARITY_EN: when defined, add output out_parity (1 bit) carrying even parity of out_data, valid with out_valid.
REQ-033 When CONV_READER_PARITY_EN is undefined, the out_parity port and its logic are absent.

Structure
REQ-034 Package conv_pkg holds the reader_state_t enum and the default DATA_W/ADDR_W/DEPTH constants; the package is shared with the convolution core.
REQ-035 The 2-entry buffer is sub-module conv_fifo2 (parameter DATA_W; push, pop, full, empty, count).

Verification
REQ-036 memZ preloaded 0x11..0x88, result_len=8, out_ready=1 → 8 consecutive beats 0x11..0x88, out_last on 0x88, rd_done 1 cycle later.
REQ-037 Same data, out_ready toggling 1/0 each cycle → identical sequence, no duplicates or drops, out_data stable while stalled.
REQ-038 result_len=0 → no memz_rd_en, no out_valid, rd_done pulse within 2 cycles.
REQ-039 result_len=12, DEPTH=8 → exactly 8 beats, addresses 0..7 only.
REQ-040 reset=0 after beat 3 of 8, then new conv_done → frame restarts at address 0 with 8 clean beats.
REQ-041 conv_done held high during a frame → single frame only; with CONV_READER_PARITY_EN, out_parity=1 for 0x07 and 0 for 0x03.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared reader FSM state type and default convolution dimensions.
// Holds DEF_DATA_W / DEF_ADDR_W / DEF_DEPTH and reader_state_t, used by the
// result reader and the convolution core.
package conv_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DEPTH  = 8;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} reader_state_t;
endpackage

// File: rtl/conv_fifo2.sv
// conv_fifo2: two-entry FIFO buffering memZ read data ahead of the output stream.
// Ports: clk, reset (async, active-low), push/wdata (write side),
//        pop/rdata (read side; rdata is the head word), full, empty, count.
module conv_fifo2
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);
    logic [DATA_W-1:0] mem [2];
    logic wp, rp, do_push, do_pop;

    assign do_pop  = pop && !empty;
    // a push into a full FIFO is accepted when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign full    = count == 2'd2;
    assign empty   = count == 2'd0;
    assign rdata   = mem[rp];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) mem[wp] <= wdata;
            wp    <= wp ^ do_push;
            rp    <= rp ^ do_pop;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/conv_result_reader.sv
// conv_result_reader: streams convolution results from memZ to a valid/ready sink.
// Ports: clk, reset (async, active-low), conv_done/result_len (frame request),
//        memz_rd_en/memz_addr/memz_rdata (memZ read port, 1-cycle latency),
//        out_data/out_valid/out_ready/out_last (result stream),
//        busy (not IDLE), rd_done (one-cycle frame-complete pulse).
// Optional: define CONV_READER_PARITY_EN to add out_parity (even parity of out_data).
module conv_result_reader
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              conv_done,
    input  logic [ADDR_W:0]   result_len,
    output logic              memz_rd_en,
    output logic [ADDR_W-1:0] memz_addr,
    input  logic [DATA_W-1:0] memz_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
`ifdef CONV_READER_PARITY_EN
    output logic              out_parity,
`endif
    output logic              busy,
    output logic              rd_done
);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    reader_state_t     state, state_nx;
    logic [ADDR_W:0]   len, beat_cnt, start_len;
    logic [ADDR_W-1:0] rd_ptr;
    logic [1:0]        count, occ;
    logic              in_flight, full, empty, pop, issue, last_rd, last_beat;

    conv_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_flight),
        .pop   (pop),
        .wdata (memz_rdata),
        .rdata (out_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign start_len = result_len > DEPTH_L ? DEPTH_L : result_len;
    assign pop       = !empty && out_ready;
    // occupancy once this cycle's pop and in-flight return settle; keeping it
    // below 2 lets a read issue every cycle while the sink keeps accepting
    assign occ       = count - 2'(pop) + 2'(in_flight);
    assign issue     = state == READ && (!full || pop) && occ < 2'd2;
    assign last_rd   = {1'b0, rd_ptr} == len - ONE;
    assign last_beat = beat_cnt == len - ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE  ? (conv_done ? (start_len == '0 ? FINISH : READ) : IDLE) :
                   state == READ  ? (issue && last_rd ? DRAIN : READ) :
                   state == DRAIN ? (pop && last_beat ? FINISH : DRAIN) : IDLE;
    end

    always_comb begin
        memz_rd_en = issue;
        memz_addr  = rd_ptr;
        out_valid  = !empty;
        out_last   = !empty && last_beat;
        busy       = state != IDLE;
        rd_done    = state == FINISH;
    end

`ifdef CONV_READER_PARITY_EN
    assign out_parity = ^out_data;
`endif

    // rd_ptr stops at len-1 so the address never wraps past the frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len       <= '0;
            beat_cnt  <= '0;
            rd_ptr    <= '0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= issue;
            if (state == IDLE && conv_done) begin
                len      <= start_len;
                beat_cnt <= '0;
                rd_ptr   <= '0;
            end else begin
                if (issue && !last_rd) rd_ptr <= rd_ptr + ADDR_W'(1);
                if (pop) beat_cnt <= beat_cnt + ONE;
            end
        end
    end
endmodule
